tower_call_panel: RTL

TOWER_CALL_PANEL -- requirements
Module: tower_call_panel

---
 rtl/tower_call_panel.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tower_call_panel.sv
// Hall call panel for a two-floor car: debounces the floor buttons, latches calls,
// and hands one trip at a time to the motion controller as a level request.
module tower_call_panel #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_F1,
  input  logic btn_F2,
  input  logic sensor_F1,
  input  logic sensor_F2,
  input  logic motor_up,
  input  logic motor_down,
  input  logic door_open,
  output logic request_F1,
  output logic request_F2,
  output logic lamp_F1,
  output logic lamp_F2,
  output logic busy,
  output logic fault
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    PARKED  = 2'd0,
    REQUEST = 2'd1,
    TRAVEL  = 2'd2
  } state_t;

  // Floor index: bit 0 = F1, bit 1 = F2
  logic [1:0]          w_btn;
  logic [1:0]          w_sensor;
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_press;
  logic [1:0][CW-1:0]  r_cnt;
  logic [1:0][CW-1:0]  w_cnt_nxt;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_target;
  logic                w_target_nxt;
  logic                r_car;
  logic                w_car_nxt;
  logic [DW-1:0]       r_dwell;
  logic [DW-1:0]       w_dwell_nxt;
  logic [1:0]          r_call;
  logic [1:0]          w_call_nxt;
  logic [1:0]          w_clr;
  logic [1:0]          w_ignore;
  logic                w_ack;
  logic                w_wrong_dir;
  logic                w_fault_nxt;

  assign w_btn    = {btn_F2, btn_F1};
  assign w_sensor = {sensor_F2, sensor_F1};

  // Debounce counters saturate so a held button produces a single press pulse
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < 2; i++) begin
      if (r_sync2[i]) begin
        w_cnt_nxt[i] = (r_cnt[i] == DEB_MAX) ? r_cnt[i] : r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cnt   <= '0;
      r_press <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_nxt;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= (w_cnt_nxt[i] == DEB_MAX) && (r_cnt[i] != DEB_MAX);
      end
    end
  end

  assign w_ack       = r_target ? motor_up : motor_down;
  assign w_wrong_dir = r_target ? motor_down : motor_up;

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_car_nxt    = r_car;
    w_dwell_nxt  = '0;
    w_clr        = '0;
    w_ignore     = '0;
    w_call_nxt   = r_call;
    w_fault_nxt  = r_fault_src();

    case (r_state)
      PARKED: begin
        if (door_open) begin
          w_dwell_nxt = (r_dwell == DWELL_MAX) ? r_dwell : r_dwell + DW'(1);
        end
        if ((r_dwell == DWELL_MAX) && r_call[~r_car]) begin
          w_state_nxt  = REQUEST;
          w_target_nxt = ~r_car;
          w_dwell_nxt  = '0;
        end
      end
      REQUEST: begin
        if (w_ack) begin
          w_state_nxt = TRAVEL;
        end
      end
      TRAVEL: begin
        if (door_open && w_sensor[r_target]) begin
          w_state_nxt     = PARKED;
          w_car_nxt       = r_target;
          w_clr[r_target] = 1'b1;
        end
      end
      default: begin
        w_state_nxt = PARKED;
      end
    endcase

    // A clear on arrival takes priority over a coincident press
    for (int i = 0; i < 2; i++) begin
      w_ignore[i] = ((r_state == PARKED) && (r_car == 1'(i)) && door_open) ||
                    ((r_state != PARKED) && (r_target == 1'(i)));
      w_call_nxt[i] = w_clr[i] ? 1'b0 : (r_call[i] | (r_press[i] & ~w_ignore[i]));
    end
  end

  function automatic logic r_fault_src();
    return fault | (motor_up & motor_down) | (sensor_F1 & sensor_F2) |
           ((r_state != PARKED) & w_wrong_dir);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PARKED;
      r_target   <= 1'b0;
      r_car      <= 1'b0;
      r_dwell    <= '0;
      r_call     <= '0;
      request_F1 <= 1'b0;
      request_F2 <= 1'b0;
      lamp_F1    <= 1'b0;
      lamp_F2    <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_car      <= w_car_nxt;
      r_dwell    <= w_dwell_nxt;
      r_call     <= w_call_nxt;
      request_F1 <= (w_state_nxt == REQUEST) && !w_target_nxt;
      request_F2 <= (w_state_nxt == REQUEST) && w_target_nxt;
      lamp_F1    <= w_call_nxt[0];
      lamp_F2    <= w_call_nxt[1];
      busy       <= (w_state_nxt != PARKED);
      fault      <= w_fault_nxt;
    end
  end

endmodule
